// File: rtl/cos_stream_accum_pkg.sv
// cos_accum_pkg: shared fixed-point types, FSM states and CORDIC constants for cos_stream_accum
package cos_accum_pkg;
  localparam int DEF_FRAC_BITS = 30;
  localparam int DEF_ACC_W = 48;
  localparam int ONE_Q = 2 ** DEF_FRAC_BITS;
  typedef logic signed [DEF_FRAC_BITS+1:0] fx_t;
  typedef logic signed [DEF_ACC_W-1:0] acc_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [31:0] K_Q30 = 32'h26DD3B6A;
  localparam logic [31:0] ATAN_Q30 [0:31] = '{
    32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
    32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
    32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
    32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
    32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
    32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F,
    32'h0000003F, 32'h0000001F, 32'h0000000F, 32'h00000008,
    32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
  };
  function automatic longint q30_scale(input logic [31:0] v, input int f);
    longint r;
    r = longint'(v);
    if (f >= 30) return r <<< (f - 30);
    return r >>> (30 - f);
  endfunction
endpackage

// File: rtl/cos_stream_accum_cordic_cos.sv
// cordic_cos: combinational rotation-mode CORDIC returning cos(i_theta), |i_theta| <= pi/2
module cordic_cos import cos_accum_pkg::*; #(
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int NUM_ITER = 30
)(
  input  logic signed [FRAC_BITS+1:0] i_theta,
  output logic signed [FRAC_BITS+1:0] o_cos
);
  localparam int W = FRAC_BITS + 2;
  logic signed [W-1:0] w_x, w_y, w_z, w_dx, w_dy;
  // unrolled micro-rotations; x starts at the CORDIC gain so no output scaling is needed
  always_comb begin
    w_x = W'(q30_scale(K_Q30, FRAC_BITS));
    w_y = '0;
    w_z = i_theta;
    w_dx = '0;
    w_dy = '0;
    for (int i = 0; i < NUM_ITER; i++) begin
      w_dx = w_y >>> i;
      w_dy = w_x >>> i;
      w_x = w_z[W-1] ? w_x + w_dx : w_x - w_dx;
      w_y = w_z[W-1] ? w_y - w_dy : w_y + w_dy;
      w_z = w_z[W-1] ? w_z + W'(q30_scale(ATAN_Q30[i], FRAC_BITS)) : w_z - W'(q30_scale(ATAN_Q30[i], FRAC_BITS));
    end
  end
  assign o_cos = w_x;
endmodule

// File: rtl/cos_stream_accum.sv
// cos_stream_accum: streaming burst sum of cos(theta); optional saturating add via COS_ACC_SAT_EN
module cos_stream_accum import cos_accum_pkg::*; #(
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int NUM_ITER = 30,
  parameter int LEN_W = 16,
  parameter int ACC_W = DEF_ACC_W
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LEN_W-1:0]            len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [FRAC_BITS+1:0] theta,
  output logic                        sum_valid,
  input  logic                        sum_ready,
  output logic [ACC_W-1:0]            sum,
  output logic                        busy,
  output logic                        ovf
);
  localparam int W = FRAC_BITS + 2;
  state_t r_state, w_next;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic signed [W-1:0] r_theta, w_cos;
  logic signed [ACC_W-1:0] r_cos, r_acc, w_acc_nxt;
  logic r_v1, r_v2, w_accept, w_start;
  assign w_accept = in_valid && r_state == RUN;
  assign w_start = start && r_state == IDLE;
  assign in_ready = r_state == RUN;
  assign sum_valid = r_state == DONE;
  assign busy = r_state != IDLE;
  assign sum = r_acc;
  cordic_cos #(.FRAC_BITS(FRAC_BITS), .NUM_ITER(NUM_ITER)) u_cordic (
    .i_theta(r_theta),
    .o_cos(w_cos)
  );
`ifdef COS_ACC_SAT_EN
  logic signed [ACC_W:0] w_ext;
  logic w_clamp, r_ovf;
  assign w_ext = {r_acc[ACC_W-1], r_acc} + {r_cos[ACC_W-1], r_cos};
  assign w_clamp = w_ext[ACC_W] != w_ext[ACC_W-1];
  assign w_acc_nxt = w_clamp ? {w_ext[ACC_W], {(ACC_W-1){~w_ext[ACC_W]}}} : w_ext[ACC_W-1:0];
  assign ovf = r_ovf;
  // sticky clamp flag, cleared by each accepted start
  always_ff @(posedge clk) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (w_start) r_ovf <= 1'b0;
    else if (r_v2 && w_clamp) r_ovf <= 1'b1;
  end
`else
  assign w_acc_nxt = r_acc + r_cos;
  assign ovf = 1'b0;
`endif
  // next state: run until len accepts, drain the two pipe stages, hold the sum until taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (len == '0) ? DONE : RUN;
      RUN:     if (w_accept && r_cnt + LEN_W'(1) == r_len) w_next = DRAIN;
      DRAIN:   if (!r_v1 && !r_v2) w_next = DONE;
      DONE:    if (sum_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // two-stage pipe: registered angle, then registered sign-extended cosine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_theta <= '0;
      r_v1 <= 1'b0;
      r_cos <= '0;
      r_v2 <= 1'b0;
    end else begin
      r_theta <= w_accept ? theta : r_theta;
      r_v1 <= w_accept;
      r_cos <= {{(ACC_W-W){w_cos[W-1]}}, w_cos};
      r_v2 <= r_v1;
    end
  end
  // burst bookkeeping and accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len <= '0;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_start) begin
      r_len <= len;
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      r_cnt <= w_accept ? r_cnt + LEN_W'(1) : r_cnt;
      r_acc <= r_v2 ? w_acc_nxt : r_acc;
    end
  end
endmodule
